// File: rtl/loop_nest_sequencer_if.sv
// Stream, config and PE-column bundle of the loop-nest sequencer.
// The master drives config/start/stream, the slave returns status and column issue data.
interface loop_nest_sequencer_if #(
   parameter int unsigned NUM_LOOPS  = 3,
   parameter int unsigned NUM_COL    = 6,
   parameter int unsigned DWIDTH_INT = 32,
   parameter int unsigned ADDR_W     = 5
);
   logic                          cfg_wr_en;
   logic [7:0]                    cfg_wr_add;
   logic [DWIDTH_INT-1:0]         cfg_wr_data;
   logic                          cfg_err;
   logic                          start;
   logic                          in_valid;
   logic                          in_ready;
   logic                          busy;
   logic                          done;
   logic [NUM_COL-1:0]            col_valid;
   logic [NUM_COL*DWIDTH_INT-1:0] col_itr;
   logic [NUM_COL*ADDR_W-1:0]     col_ptr;

   modport master (
      output cfg_wr_en, cfg_wr_add, cfg_wr_data, start, in_valid,
      input  cfg_err, in_ready, busy, done, col_valid, col_itr, col_ptr
   );

   modport slave (
      input  cfg_wr_en, cfg_wr_add, cfg_wr_data, start, in_valid,
      output cfg_err, in_ready, busy, done, col_valid, col_itr, col_ptr
   );
endinterface

// File: rtl/loop_nest_sequencer.sv
// Runtime-configured odometer loop nest: one iteration vector + table pointer per handshake,
// fanned out to PE columns through per-column delay taps and an iterator-select mux.
module loop_nest_sequencer #(
   parameter int unsigned NUM_LOOPS  = 3,
   parameter int unsigned NUM_COL    = 6,
   parameter int unsigned DWIDTH_INT = 32,
   parameter int unsigned ADDR_W     = 5,
   parameter int unsigned STAGE_LAT  = 4,
   parameter int unsigned SEL_W      = (NUM_LOOPS > 1) ? $clog2(NUM_LOOPS) : 1
) (
   input logic                  clk,
   input logic                  rst,
   loop_nest_sequencer_if.slave bus
);

   localparam int unsigned DrainLat = (NUM_COL - 1) * STAGE_LAT;
   localparam int unsigned CntW     = (DrainLat > 1) ? $clog2(DrainLat) : 1;
   localparam int unsigned NumCfg   = NUM_LOOPS + 2 + NUM_COL;

   typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

   typedef struct packed {
      logic                                  valid;
      logic [NUM_LOOPS-1:0][DWIDTH_INT-1:0]  itr;
      logic [ADDR_W-1:0]                     ptr;
   } stage_t;

   state_e state_q, state_d;
   logic   done_q, done_d;
   logic   cfg_err_q;
   logic [CntW-1:0] cnt_q;

   logic [NUM_LOOPS-1:0][DWIDTH_INT-1:0] bound_q, wbound_q, itr_q, itr_nxt;
   logic [ADDR_W-1:0]                    ptr_base_q, ptr_len_q, wbase_q, wlen_q;
   logic [ADDR_W-1:0]                    sptr_q, sptr_nxt, sptr_end;
   logic [NUM_COL-1:0][SEL_W-1:0]        sel_q, wsel_q;
   stage_t                               pipe_q [DrainLat+1];

   logic hs, is_last, cfg_ok;

   assign hs     = bus.in_valid && (state_q == StRun);
   assign cfg_ok = (state_q == StIdle) && (32'(bus.cfg_wr_add) < NumCfg);

   // Odometer: level 0 innermost, carry ripples outward on wrap.
   always_comb begin
      logic carry;
      logic wrap;
      itr_nxt = itr_q;
      is_last = 1'b1;
      carry   = 1'b1;
      for (int l = 0; l < NUM_LOOPS; l++) begin
         wrap = (itr_q[l] == wbound_q[l] - DWIDTH_INT'(1));
         if (!wrap) is_last = 1'b0;
         if (carry) begin
            if (wrap) begin
               itr_nxt[l] = '0;
            end else begin
               itr_nxt[l] = itr_q[l] + DWIDTH_INT'(1);
               carry      = 1'b0;
            end
         end
      end
   end

   assign sptr_end = wbase_q + wlen_q - ADDR_W'(1);
   assign sptr_nxt = (sptr_q == sptr_end) ? wbase_q : sptr_q + ADDR_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         done_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
         cnt_q   <= (state_q == StDrain) ? cnt_q + CntW'(1) : '0;
      end
   end

   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      unique case (state_q)
         StIdle: if (bus.start) state_d = StRun;
         StRun: begin
            if (hs && is_last) begin
               if (DrainLat == 0) begin
                  state_d = StIdle;
                  done_d  = 1'b1;
               end else begin
                  state_d = StDrain;
               end
            end
         end
         StDrain: begin
            if (cnt_q == CntW'(DrainLat - 1)) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      bus.in_ready  = (state_q == StRun);
      bus.busy      = (state_q != StIdle);
      bus.done      = done_q;
      bus.cfg_err   = cfg_err_q;
      bus.col_valid = '0;
      bus.col_itr   = '0;
      bus.col_ptr   = '0;
      for (int c = 0; c < NUM_COL; c++) begin
         bus.col_valid[c]                 = pipe_q[c*STAGE_LAT].valid;
         bus.col_ptr[c*ADDR_W +: ADDR_W] = pipe_q[c*STAGE_LAT].ptr;
         if (32'(wsel_q[c]) < NUM_LOOPS) begin
            bus.col_itr[c*DWIDTH_INT +: DWIDTH_INT] = pipe_q[c*STAGE_LAT].itr[wsel_q[c]];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int l = 0; l < NUM_LOOPS; l++) bound_q[l] <= DWIDTH_INT'(1);
         ptr_base_q <= '0;
         ptr_len_q  <= ADDR_W'(1);
         sel_q      <= '0;
         cfg_err_q  <= 1'b0;
      end else begin
         cfg_err_q <= bus.cfg_wr_en && !cfg_ok;
         if (bus.cfg_wr_en && cfg_ok) begin
            for (int l = 0; l < NUM_LOOPS; l++) begin
               if (bus.cfg_wr_add == 8'(l)) bound_q[l] <= bus.cfg_wr_data;
            end
            if (bus.cfg_wr_add == 8'(NUM_LOOPS)) ptr_base_q <= bus.cfg_wr_data[ADDR_W-1:0];
            if (bus.cfg_wr_add == 8'(NUM_LOOPS + 1)) ptr_len_q <= bus.cfg_wr_data[ADDR_W-1:0];
            for (int c = 0; c < NUM_COL; c++) begin
               if (bus.cfg_wr_add == 8'(NUM_LOOPS + 2 + c)) sel_q[c] <= bus.cfg_wr_data[SEL_W-1:0];
            end
         end
      end
   end

   // Working copies are frozen at start so IDLE-side writes never disturb a run.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int l = 0; l < NUM_LOOPS; l++) wbound_q[l] <= DWIDTH_INT'(1);
         wbase_q <= '0;
         wlen_q  <= ADDR_W'(1);
         wsel_q  <= '0;
         itr_q   <= '0;
         sptr_q  <= '0;
      end else if (state_q == StIdle && bus.start) begin
         for (int l = 0; l < NUM_LOOPS; l++) begin
            wbound_q[l] <= (bound_q[l] == '0) ? DWIDTH_INT'(1) : bound_q[l];
         end
         wbase_q <= ptr_base_q;
         wlen_q  <= (ptr_len_q == '0) ? ADDR_W'(1) : ptr_len_q;
         wsel_q  <= sel_q;
         itr_q   <= '0;
         sptr_q  <= ptr_base_q;
      end else if (hs) begin
         itr_q  <= itr_nxt;
         sptr_q <= sptr_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i <= DrainLat; i++) pipe_q[i] <= '0;
      end else begin
         pipe_q[0].valid <= hs;
         if (hs) begin
            pipe_q[0].itr <= itr_q;
            pipe_q[0].ptr <= sptr_q;
         end
         for (int i = 1; i <= DrainLat; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

endmodule
